// File: rtl/modport_ram_if.sv
// Bus bundle for the modport_ram storage block.
// The write and read driver/monitor pairs share this bundle. clk and rstn are
// kept as plain module ports.
interface modport_ram_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data_in;
  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] data_out;

  // Driver side: it drives the strobes, addresses and write data, and sees
  // the read data.
  modport master (
    output write_enable,
    output write_address,
    output data_in,
    output read_enable,
    output read_address,
    input  data_out
  );

  // RAM side: it consumes the strobes and returns the registered read data.
  modport slave (
    input  write_enable,
    input  write_address,
    input  data_in,
    input  read_enable,
    input  read_address,
    output data_out
  );

  // Passive observer of every signal.
  modport monitor (
    input write_enable,
    input write_address,
    input data_in,
    input read_enable,
    input read_address,
    input data_out
  );

endinterface

// File: rtl/modport_ram.sv
// modport_ram: 32 x 32-bit RAM with one write port and one read port.
// Reset clears every word and the read register. Read data is registered.
// A read and a write to the same address at the same edge return the data
// being written, so the read is write-first.
module modport_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rstn,            // synchronous, active-high despite the name
  modport_ram_if.slave bus
);

  // Storage is a flop array rather than block RAM, so that one reset edge
  // can clear every word.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  wr_sel;

  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic [DATA_W-1:0] rd_word;
  logic              rd_bypass;

  // Decode the write address into a one-hot word select, gated by the strobe.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = bus.write_enable && (bus.write_address == ADDR_W'(i));
    end
  end

  // Next-state contents of each word. A selected word takes data_in and
  // every other word holds its value.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_sel[i]) begin
        mem_d[i] = bus.data_in;
      end
    end
  end

  // Storage register. Reset dominates any write presented at the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rstn) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read selection. A write to the address being read at the same edge is
  // forwarded from data_in, so the reader never sees stale data.
  always_comb begin
    rd_word    = mem_q[bus.read_address];
    rd_bypass  = bus.write_enable && (bus.write_address == bus.read_address);
    data_out_d = data_out_q;
    if (bus.read_enable) begin
      data_out_d = rd_bypass ? bus.data_in : rd_word;
    end
  end

  // Read data register. It holds its value between reads and is cleared only
  // by reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_modport_ram.sv
// Directed and random bench for modport_ram.
// Inputs are driven 2 ns after a rising edge. data_out is sampled 1 ns after
// the edge that performed the read.
module tb_modport_ram;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  // Reference contents, used only by the random traffic test.
  logic [31:0] model_mem [32];
  logic [31:0] model_out;

  modport_ram_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  modport_ram #(.DEPTH(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then return 1 ns after the edge that samples
  // them.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] din, input logic re, input logic [4:0] ra);
    #1;
    rstn              = rst;
    bus.write_enable  = we;
    bus.write_address = wa;
    bus.data_in       = din;
    bus.read_enable   = re;
    bus.read_address  = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    n_checks++;
    $display("reset edge 1: data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_edge got=%h exp=%h", bus.data_out, 32'h0);
    end
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    n_checks++;
    $display("reset edge 2: data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", bus.data_out, 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a));
      n_checks++;
      $display("read after reset a=%0d data_out=%h", a, bus.data_out);
      if (bus.data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read a=%0d got=%h exp=%h", a, bus.data_out, 32'h0);
      end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] exp;
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 5'(a), 32'hA5A5_0000 | 32'(a), 1'b0, 5'd0);
      $display("write a=%0d data=%h", a, 32'hA5A5_0000 | 32'(a));
    end
    for (int a = 0; a < 32; a++) begin
      exp = 32'hA5A5_0000 | 32'(a);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a));
      n_checks++;
      $display("sweep read a=%0d data_out=%h exp=%h", a, bus.data_out, exp);
      if (bus.data_out !== exp) begin
        n_fail++;
        $display("FAIL sweep_read a=%0d got=%h exp=%h", a, bus.data_out, exp);
      end
    end
  endtask

  task automatic test_hold_overwrite;
    step(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    n_checks++;
    $display("hold read a=7 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL hold_read got=%h exp=%h", bus.data_out, 32'hDEAD_BEEF);
    end
    // Idle cycles: the read address moves and write data targets addr 7, but
    // both strobes stay low.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'd7, 32'h0BAD_0BAD, 1'b0, 5'(i + 1));
      n_checks++;
      $display("hold idle %0d data_out=%h", i, bus.data_out);
      if (bus.data_out !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL hold_idle%0d got=%h exp=%h", i, bus.data_out, 32'hDEAD_BEEF);
      end
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    n_checks++;
    $display("no-write read a=7 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL we_low_nowrite got=%h exp=%h", bus.data_out, 32'hDEAD_BEEF);
    end
    step(1'b0, 1'b1, 5'd7, 32'h1111_2222, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    n_checks++;
    $display("overwrite read a=7 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL last_write_wins got=%h exp=%h", bus.data_out, 32'h1234_5678);
    end
  endtask

  task automatic test_collision;
    step(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b1, 5'd12);
    n_checks++;
    $display("collision same a=12 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL collide_same got=%h exp=%h", bus.data_out, 32'hCAFE_F00D);
    end
    // Writing 12 while reading 13 must return the old contents of 13.
    step(1'b0, 1'b1, 5'd12, 32'h0BEE_F012, 1'b1, 5'd13);
    n_checks++;
    $display("collision diff rd=13 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'hA5A5_000D) begin
      n_fail++;
      $display("FAIL collide_diff got=%h exp=%h", bus.data_out, 32'hA5A5_000D);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    n_checks++;
    $display("collision readback a=12 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0BEE_F012) begin
      n_fail++;
      $display("FAIL collide_readback got=%h exp=%h", bus.data_out, 32'h0BEE_F012);
    end
  endtask

  task automatic test_reset_midstream;
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    n_checks++;
    $display("pre-reset read a=3 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'hA5A5_0003) begin
      n_fail++;
      $display("FAIL premid_read got=%h exp=%h", bus.data_out, 32'hA5A5_0003);
    end
    step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3);
    n_checks++;
    $display("mid reset edge data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_out got=%h exp=%h", bus.data_out, 32'h0);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    n_checks++;
    $display("post-reset read a=3 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_addr3 got=%h exp=%h", bus.data_out, 32'h0);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31);
    n_checks++;
    $display("post-reset read a=31 data_out=%h", bus.data_out);
    if (bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_addr31 got=%h exp=%h", bus.data_out, 32'h0);
    end
  endtask

  task automatic test_random;
    logic        rst;
    logic        we;
    logic        re;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [31:0] din;
    // Memory was cleared by the preceding reset, and data_out reads 0.
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_out = 32'h0;
    for (int c = 0; c < 1000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      // Reuse the write address often so that collisions occur.
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      din = $urandom;
      if (rst) begin
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
        model_out = 32'h0;
      end else begin
        if (re) model_out = (we && wa == ra) ? din : model_mem[ra];
        if (we) model_mem[wa] = din;
      end
      step(rst, we, wa, din, re, ra);
      n_checks++;
      $display("rnd %0d rst=%b we=%b wa=%0d re=%b ra=%0d out=%h exp=%h",
               c, rst, we, wa, re, ra, bus.data_out, model_out);
      if (bus.data_out !== model_out) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h exp=%h", c, bus.data_out, model_out);
      end
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rstn              = 1'b1;
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.data_in       = '0;
    bus.read_enable   = 1'b0;
    bus.read_address  = '0;
    test_reset();
    test_sweep();
    test_hold_overwrite();
    test_collision();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
